// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial sequence detector.
//   PKG_MAX_LEN : pattern capacity in bits
//   LEN_W       : width of a pattern-length field
//   cfg_t       : latched configuration {pattern, len, overlap}
//   len_valid() : true when a length can be armed (2..PKG_MAX_LEN)
package seq_detect_pkg;

  localparam int unsigned PKG_MAX_LEN = 8;
  localparam int unsigned LEN_W       = $clog2(PKG_MAX_LEN + 1);

  typedef struct packed {
    logic [PKG_MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]       len;
    logic                   overlap;
  } cfg_t;

  function automatic logic len_valid(input logic [LEN_W-1:0] len);
    return (len >= LEN_W'(2)) && (32'(len) <= PKG_MAX_LEN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : increment by one, holding at all-ones
//   count    : registered count value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector with match counting.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid,din : valid-qualified serial input bit
//   cfg_load     : strobe latching cfg_pattern / cfg_len / cfg_overlap
//   match        : registered one-cycle pulse per detected match
//   match_count  : saturating number of matches since reset / cfg_load
//   armed        : latched configuration has a usable length
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = PKG_MAX_LEN,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  // The configuration struct is sized by the package capacity.
  if ((MAX_LEN != PKG_MAX_LEN) || (MAX_LEN < 2)) begin : g_bad_max_len
    $error("seq_detect_prog: MAX_LEN must equal PKG_MAX_LEN and be >= 2");
  end

  cfg_t               cfg_q,   cfg_d;
  logic               armed_q, armed_d;
  logic [MAX_LEN-1:0] hist_q,  hist_d;
  logic [LEN_W-1:0]   fill_q,  fill_d;
  logic               match_q, match_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  // Candidate next history/fill for an accepted bit, and the match test on them.
  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], din};
    fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    // len == MAX_LEN shifts the 1 out, so the subtraction yields all ones.
    len_mask   = (MAX_LEN'(1) << cfg_q.len) - MAX_LEN'(1);
    hit        = armed_q && (fill_inc >= cfg_q.len) &&
                 (((hist_shift ^ cfg_q.pattern) & len_mask) == '0);
  end

  // Next-state: cfg_load takes precedence over an accepted bit.
  always_comb begin
    cfg_d   = cfg_q;
    armed_d = armed_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (cfg_load) begin
      cfg_d   = '{pattern: cfg_pattern, len: cfg_len, overlap: cfg_overlap};
      armed_d = len_valid(cfg_len);
      hist_d  = '0;
      fill_d  = '0;
    end else if (in_valid) begin
      hist_d  = hist_shift;
      fill_d  = fill_inc;
      match_d = hit;
      // Non-overlap: a matched run cannot contribute to the next match.
      if (hit && !cfg_q.overlap) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q   <= '{pattern: '0, len: '0, overlap: 1'b1};
      armed_q <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      armed_q <= armed_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cfg_load),
    .inc   (match_d),
    .count (match_count)
  );

  assign match = match_q;
  assign armed = armed_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: explicit vector table, directed
// corner sequences and randomized traffic against a bit-queue reference model.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_seq_detect_prog;

  localparam int unsigned ML = 8;

  logic       clk = 1'b0;
  logic       rst, in_valid, din, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       match, armed, match_s, armed_s;
  logic [7:0] match_count;
  logic [1:0] match_count_s;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(ML), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match), .match_count(match_count),
    .armed(armed)
  );

  seq_detect_prog #(.MAX_LEN(ML), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match_s), .match_count(match_count_s),
    .armed(armed_s)
  );

  // Reference model: the bits accepted since the last clear, oldest first.
  bit         q_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl, m_armed, m_match;
  int         m_cnt, m_cnt_s;

  function automatic bit tail_matches();
    if (q_bits.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (q_bits[q_bits.size() - 1 - i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, ld, input logic [7:0] p,
                            input logic [3:0] l, input logic o, v, d);
    if (r) begin
      q_bits.delete();
      m_pat = '0; m_len = 0; m_ovl = 1'b1; m_armed = 1'b0;
      m_match = 1'b0; m_cnt = 0; m_cnt_s = 0;
    end else if (ld) begin
      m_pat = p; m_len = int'(l); m_ovl = o;
      m_armed = (m_len >= 2) && (m_len <= ML);
      q_bits.delete();
      m_match = 1'b0; m_cnt = 0; m_cnt_s = 0;
    end else if (v) begin
      q_bits.push_back(d);
      if (q_bits.size() > ML) void'(q_bits.pop_front());
      m_match = m_armed && tail_matches();
      if (m_match) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
        if (!m_ovl) q_bits.delete();
      end
    end else begin
      m_match = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    tests++;
    if (match !== m_match || armed !== m_armed || match_count !== 8'(m_cnt) ||
        match_s !== m_match || armed_s !== m_armed ||
        match_count_s !== 2'(m_cnt_s)) begin
      fails++;
      $display("FAIL %s cyc=%0d: got match=%0b/%0b armed=%0b/%0b cnt=%0d cnt2=%0d, want match=%0b armed=%0b cnt=%0d cnt2=%0d",
               tag, cyc, match, match_s, armed, armed_s, match_count,
               match_count_s, m_match, m_armed, m_cnt, m_cnt_s);
    end
  endtask

  task automatic cycle(input string tag, input logic r, ld, input logic [7:0] p,
                       input logic [3:0] l, input logic o, v, d);
    rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = l;
    cfg_overlap = o; in_valid = v; din = d;
    @(posedge clk);
    model_step(r, ld, p, l, o, v, d);
    cyc++;
    #1;
    check_model(tag);
  endtask

  task automatic send(input string tag, input logic d);
    cycle(tag, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // din=1 with in_valid=1 on the load cycle must be ignored.
  task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l,
                      input logic o);
    cycle(tag, 1'b0, 1'b1, p, l, o, 1'b1, 1'b1);
  endtask

  task automatic do_rst(input string tag);
    cycle(tag, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic expect_val(input string tag, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0d, want %0d", tag, cyc, got, want);
    end
  endtask

  typedef struct {
    logic       r, ld;
    logic [7:0] p;
    logic [3:0] l;
    logic       o, v, d;
    logic       e_match, e_armed;
    int         e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, ld, input logic [7:0] p,
                              input logic [3:0] l, input logic o, v, d,
                              input logic em, ea, input int ec);
    vec_t t;
    t.r = r; t.ld = ld; t.p = p; t.l = l; t.o = o; t.v = v; t.d = d;
    t.e_match = em; t.e_armed = ea; t.e_cnt = ec;
    return t;
  endfunction

  initial begin
    // Overlap basic then non-overlap on the same stream 1,0,1,1,0,1,1.
    tbl.push_back(mk(1, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h0B, 4'd4, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 1, 8'h0B, 4'd4, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 1, 1));

    foreach (tbl[i]) begin
      cycle("tbl_model", tbl[i].r, tbl[i].ld, tbl[i].p, tbl[i].l, tbl[i].o,
            tbl[i].v, tbl[i].d);
      tests++;
      if (match !== tbl[i].e_match || armed !== tbl[i].e_armed ||
          match_count !== 8'(tbl[i].e_cnt)) begin
        fails++;
        $display("FAIL tbl[%0d]: got match=%0b armed=%0b cnt=%0d, want match=%0b armed=%0b cnt=%0d",
                 i, match, armed, match_count, tbl[i].e_match, tbl[i].e_armed,
                 tbl[i].e_cnt);
      end
    end

    // Valid gaps: 3 idle cycles between each bit of 1011.
    load("gap_load", 8'h0B, 4'd4, 1'b1);
    begin
      logic [3:0] s;
      s = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        send("gap_bit", s[i]);
        for (int k = 0; k < 3; k++) idle("gap_idle");
      end
    end
    expect_val("gap_count", int'(match_count), 1);

    // Invalid lengths never arm; then a valid len=2 pattern 11.
    load("inv_load1", 8'h01, 4'd1, 1'b1);
    expect_val("inv_armed_len1", int'(armed), 0);
    for (int i = 0; i < 4; i++) send("inv_ones1", 1'b1);
    load("inv_load9", 8'hFF, 4'd9, 1'b1);
    expect_val("inv_armed_len9", int'(armed), 0);
    for (int i = 0; i < 12; i++) send("inv_ones9", 1'b1);
    expect_val("inv_count", int'(match_count), 0);
    load("re_load", 8'h03, 4'd2, 1'b1);
    expect_val("re_armed", int'(armed), 1);
    send("re_first", 1'b1);
    expect_val("re_first_nomatch", int'(match), 0);
    for (int i = 0; i < 4; i++) begin
      send("re_run", 1'b1);
      expect_val("re_pulse", int'(match), 1);
    end

    // Reset mid-sequence discards partial history and the configuration.
    load("rm_load", 8'h0B, 4'd4, 1'b1);
    send("rm_b", 1'b1); send("rm_b", 1'b0); send("rm_b", 1'b1);
    do_rst("rm_rst");
    expect_val("rm_armed_after_rst", int'(armed), 0);
    send("rm_last", 1'b1);
    expect_val("rm_no_match", int'(match), 0);
    load("rm_reload", 8'h0B, 4'd4, 1'b1);
    send("rm_s", 1'b1); send("rm_s", 1'b0); send("rm_s", 1'b1); send("rm_s", 1'b1);
    expect_val("rm_match", int'(match), 1);
    expect_val("rm_count", int'(match_count), 1);

    // Saturation on the CNT_W=2 instance.
    load("sat_load", 8'h03, 4'd2, 1'b1);
    for (int i = 0; i < 10; i++) send("sat_run", 1'b1);
    expect_val("sat_count2", int'(match_count_s), 3);
    expect_val("sat_count8", int'(match_count), 9);
    expect_val("sat_still_pulsing", int'(match_s), 1);
    load("sat_clear", 8'h03, 4'd2, 1'b1);
    expect_val("sat_cleared", int'(match_count_s), 0);

    // Randomized traffic; short patterns keep matches frequent.
    load("rnd_init", 8'(($urandom % 4) + 1), 4'd3, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        do_rst("rnd_rst");
      end else if (r < 10) begin
        load("rnd_load", 8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom));
      end else begin
        cycle("rnd_bit", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0,
              1'($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Parametrised, runtime-programmable serial bit-sequence detector.
- Generalises the fixed 1011 Moore detector: pattern and length are loadable (up to MAX_LEN bits), overlap/non-overlap is selectable, input is valid-qualified, and matches are counted.
- Sits between a serial bit source and control/status logic; `match` is a registered single-cycle pulse.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: width of the saturating match counter.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: din is sampled only when high.
- din, input, 1: serial data bit.
- cfg_load, input, 1: one-cycle strobe that latches the configuration inputs.
- cfg_pattern, input, MAX_LEN: pattern bits; bit [len-1] is the oldest expected bit, bit [0] the newest.
- cfg_len, input, $clog2(MAX_LEN+1): pattern length.
- cfg_overlap, input, 1: 1 = overlapping matches allowed; 0 = matched bits are consumed.
- match, output, 1: Moore pulse, high exactly one cycle per detected match.
- match_count, output, CNT_W: number of matches since reset/cfg_load, saturating.
- armed, output, 1: latched configuration is valid (2 ≤ len ≤ MAX_LEN).

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - history = 0, fill = 0, match = 0, match_count = 0.
  - Latched pattern = 0, len = 0, overlap = 1, so armed = 0.
- Internal state:
  - history: MAX_LEN-bit shift register. On an accepted bit, history <= {history[MAX_LEN-2:0], din}.
  - fill: count of accepted bits since the last clear, saturating at MAX_LEN.
- cfg_load=1:
  - Latch pattern, len and overlap.
  - Clear history, fill and match_count; match <= 0.
  - din is ignored that cycle even if in_valid=1.
- armed = registered, (latched len ≥ 2) && (latched len ≤ MAX_LEN). It updates the cycle after cfg_load. When armed=0, match never asserts and the counter holds.
- Match condition, evaluated on the accepted bit, using next-state history/fill:
  - armed && in_valid && (fill_next ≥ len) && (history_next[len-1:0] == pattern[len-1:0]).
  - match is registered: high in the cycle after the posedge that sampled the final pattern bit. This is a Moore output with one-cycle latency.
- match is always a single-cycle pulse:
  - It drops the following cycle unless a new match occurs on that cycle's accepted bit.
  - Back-to-back pulses are legal only in overlap mode with periodic patterns (e.g. 11 on a run of 1s).
- Non-overlap mode: on a match, fill_next is forced to 0, so no bit of a matched sequence participates in a later match. History still shifts.
- Overlap mode: fill is not cleared on a match.
- in_valid=0: history, fill and the counter hold; match <= 0.
- match_count increments on each match and saturates at 2^CNT_W-1; it never wraps.
- Precedence, highest first: rst > cfg_load > accepted din.
- Reset mid-sequence: partial history is discarded and no match can fire from bits sampled before reset. The configuration returns to unarmed and must be reloaded.

Decomposition:
- Shared package seq_detect_pkg:
  - localparam LEN_W = $clog2(MAX_LEN+1).
  - Typedef cfg_t, a struct of {pattern, len, overlap}.
  - Function len_valid().
- One natural sub-module: sat_counter, holding the CNT_W saturating counter with clear/inc.
- Comparator, masking and shift register stay in the top.

Test Plan:
- Overlap basic: load pattern=1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 with in_valid=1 -> match pulses the cycle after bits 4 and 7; match_count=2.
- Non-overlap: same stream with overlap=0 -> one pulse after bit 4 only; match_count=1.
- Valid gaps: stream 1,0,1,1 with in_valid=0 for 3 cycles between each bit -> exactly one pulse, the cycle after the 4th accepted bit; no pulses during gaps.
- Invalid config: len=1, then len=9 (MAX_LEN=8), stream all 1s -> armed=0, match never asserts, count stays 0. Reload len=2, pattern=11, overlap=1 -> armed=1 next cycle and pulses every cycle from the 2nd accepted 1.
- Reset mid-sequence: after 1,0,1 assert rst for one cycle, then send 1 -> no match. Then reload 1011 and send 1,0,1,1 -> one match.
- Saturation: CNT_W=2, pattern 11 overlap, 10 consecutive 1s -> match_count stops at 3 and stays there while match keeps pulsing; cfg_load clears it to 0.
